// File: rtl/icache_if.sv
// Fetch-side and refill-side signal bundle for the instruction cache.
// slave: the cache itself; master: fetch/flow-control/memory side.
interface icache_if;
  logic [31:0] if_pc_i;
  logic        if_valid_req_i;
  logic        fc_jump_flag_i;
  logic        Icache_stall_flag_o;
  logic [31:0] Icache_inst_o;
  logic        Icache_inst_valid_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_rvalid_i;

  modport slave (
    input  if_pc_i, if_valid_req_i, fc_jump_flag_i,
    input  mem_rdata_i, mem_rvalid_i,
    output Icache_stall_flag_o, Icache_inst_o,
    output Icache_inst_valid_o, mem_req_o, mem_addr_o
  );

  modport master (
    output if_pc_i, if_valid_req_i, fc_jump_flag_i,
    output mem_rdata_i, mem_rvalid_i,
    input  Icache_stall_flag_o, Icache_inst_o,
    input  Icache_inst_valid_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, one-cycle hit latency, line refill FSM.
// Ports: clk, rst (sync, active-high), bus (icache_if.slave).
// Macro ICACHE_PERF_CNT_EN adds hit_cnt_o / miss_cnt_o counters.
module icache #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64
) (
  input  logic        clk,
  input  logic        rst,
`ifdef ICACHE_PERF_CNT_EN
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o,
`endif
  icache_if.slave     bus
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - OW - IW;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    FILL_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SETS-1:0] valid_q;
  logic [TW-1:0]   tag_mem [SETS];
  logic [31:0]     data_mem [SETS*LINE_WORDS];

  logic [OW-1:0] cnt_q;
  logic [31:0]   addr_q;
  logic [31:0]   inst_q;
  logic          ival_q;

  logic [OW-1:0] pc_off;
  logic [IW-1:0] pc_idx;
  logic [TW-1:0] pc_tag;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic          hit;
  logic          miss_start;
  logic          beat;
  logic          last;
  logic          mem_req;
  logic          stall;
  logic          unused_pc;

  assign pc_off   = bus.if_pc_i[OW+1:2];
  assign pc_idx   = bus.if_pc_i[OW+IW+1:OW+2];
  assign pc_tag   = bus.if_pc_i[31:OW+IW+2];
  assign unused_pc = ^bus.if_pc_i[1:0];

  // refill writes follow the latched miss address, not the live PC
  assign fill_idx = addr_q[OW+IW+1:OW+2];
  assign fill_tag = addr_q[31:OW+IW+2];

  assign hit = bus.if_valid_req_i & valid_q[pc_idx]
             & (tag_mem[pc_idx] == pc_tag)
             & (state_q == IDLE);
  assign miss_start = (state_q == IDLE)
                    & bus.if_valid_req_i & ~hit;
  assign beat = (state_q == REFILL) & bus.mem_rvalid_i;
  assign last = beat & (cnt_q == OW'(LINE_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (miss_start) state_d = REFILL;
      REFILL:    if (last)       state_d = FILL_DONE;
      FILL_DONE:                 state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state_q == REFILL);
    stall   = (bus.if_valid_req_i & ~hit)
            | (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      inst_q  <= '0;
      ival_q  <= 1'b0;
    end else begin
      if (miss_start) begin
        valid_q[pc_idx] <= 1'b0;
        addr_q <= {bus.if_pc_i[31:OW+2], (OW+2)'(0)};
      end
      if (state_q == FILL_DONE)
        valid_q[fill_idx] <= 1'b1;
      if (beat)
        cnt_q <= cnt_q + 1'b1;
      if (hit & ~bus.fc_jump_flag_i)
        inst_q <= data_mem[{pc_idx, pc_off}];
      ival_q <= hit & ~bus.fc_jump_flag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (beat)
      data_mem[{fill_idx, cnt_q}] <= bus.mem_rdata_i;
    if (last)
      tag_mem[fill_idx] <= fill_tag;
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit)        hit_cnt_o  <= hit_cnt_o + 1;
      if (miss_start) miss_cnt_o <= miss_cnt_o + 1;
    end
  end
`endif

  assign bus.Icache_stall_flag_o = stall;
  assign bus.Icache_inst_o       = inst_q;
  assign bus.Icache_inst_valid_o = ival_q;
  assign bus.mem_req_o           = mem_req;
  assign bus.mem_addr_o          = addr_q;
endmodule

// File: tb/tb_icache.sv
// Directed table-driven bench for icache.
// Drives bus after posedge, samples outputs 1ns later.
module tb_icache;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  icache_if bus ();

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache dut (
    .clk        (clk),
    .rst        (rst),
`ifdef ICACHE_PERF_CNT_EN
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        req;
    logic        jmp;
    logic        rv;
    logic [31:0] rd;
    logic        stall;
    logic        mreq;
    logic [31:0] addr;
    logic        ival;
    logic [31:0] inst;
  } vec_t;

  vec_t q[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic req,
                       input logic jmp, input logic rv,
                       input logic [31:0] rd);
    bus.if_pc_i        = pc;
    bus.if_valid_req_i = req;
    bus.fc_jump_flag_i = jmp;
    bus.mem_rvalid_i   = rv;
    bus.mem_rdata_i    = rd;
  endtask

  task automatic add(input logic [31:0] pc, input logic req,
                     input logic jmp, input logic rv,
                     input logic [31:0] rd, input logic st,
                     input logic mr, input logic [31:0] ad,
                     input logic iv, input logic [31:0] in);
    vec_t v;
    v.pc = pc; v.req = req; v.jmp = jmp; v.rv = rv; v.rd = rd;
    v.stall = st; v.mreq = mr; v.addr = ad;
    v.ival = iv; v.inst = in;
    q.push_back(v);
  endtask

  initial begin
    bit seen;
    checks = 0;
    errors = 0;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    tick();
    chk("rst_mreq", {31'h0, bus.mem_req_o}, 32'h0);
    chk("rst_addr", bus.mem_addr_o, 32'h0);
    chk("rst_inst", bus.Icache_inst_o, 32'h0);
    chk("rst_ival", {31'h0, bus.Icache_inst_valid_o}, 32'h0);
    chk("rst_stall", {31'h0, bus.Icache_stall_flag_o}, 32'h0);
    rst = 1'b0;

    //  pc     rq jp rv rd        st mr addr    iv inst
    add('h0,   1, 0, 0, 'h0,    1, 0, 'h0,   0, 'h0);
    add('h0,   1, 0, 1, 'hA0,   1, 1, 'h0,   0, 'h0);
    add('h0,   1, 0, 1, 'hA1,   1, 1, 'h0,   0, 'h0);
    add('h0,   1, 0, 1, 'hA2,   1, 1, 'h0,   0, 'h0);
    add('h0,   1, 0, 1, 'hA3,   1, 1, 'h0,   0, 'h0);
    add('h0,   1, 0, 1, 'hDEAD, 1, 0, 'h0,   0, 'h0);
    add('h0,   1, 0, 0, 'h0,    0, 0, 'h0,   0, 'h0);
    add('h4,   1, 0, 0, 'h0,    0, 0, 'h0,   1, 'hA0);
    add('h8,   1, 0, 0, 'h0,    0, 0, 'h0,   1, 'hA1);
    add('hC,   1, 0, 0, 'h0,    0, 0, 'h0,   1, 'hA2);
    add('hC,   0, 0, 0, 'h0,    0, 0, 'h0,   1, 'hA3);
    add('hC,   0, 0, 0, 'h0,    0, 0, 'h0,   0, 'hA3);
    add('h400, 1, 0, 0, 'h0,    1, 0, 'h0,   0, 'hA3);
    add('h400, 1, 0, 1, 'hB0,   1, 1, 'h400, 0, 'hA3);
    add('h400, 1, 0, 1, 'hB1,   1, 1, 'h400, 0, 'hA3);
    add('h400, 1, 0, 1, 'hB2,   1, 1, 'h400, 0, 'hA3);
    add('h400, 1, 0, 1, 'hB3,   1, 1, 'h400, 0, 'hA3);
    add('h400, 1, 0, 0, 'h0,    1, 0, 'h400, 0, 'hA3);
    add('h400, 1, 0, 0, 'h0,    0, 0, 'h400, 0, 'hA3);
    add('h0,   1, 0, 0, 'h0,    1, 0, 'h400, 1, 'hB0);
    add('h0,   1, 0, 1, 'hA0,   1, 1, 'h0,   0, 'hB0);
    add('h0,   1, 1, 1, 'hA1,   1, 1, 'h0,   0, 'hB0);
    add('h0,   1, 1, 1, 'hA2,   1, 1, 'h0,   0, 'hB0);
    add('h0,   1, 0, 1, 'hA3,   1, 1, 'h0,   0, 'hB0);
    add('h0,   1, 1, 0, 'h0,    1, 0, 'h0,   0, 'hB0);
    add('h0,   1, 1, 0, 'h0,    0, 0, 'h0,   0, 'hB0);
    add('h0,   1, 0, 0, 'h0,    0, 0, 'h0,   0, 'hB0);
    add('h4,   0, 0, 0, 'h0,    0, 0, 'h0,   1, 'hA0);
    add('h4,   0, 0, 0, 'h0,    0, 0, 'h0,   0, 'hA0);

    for (int i = 0; i < q.size(); i++) begin
      drive(q[i].pc, q[i].req, q[i].jmp, q[i].rv, q[i].rd);
      #1;
      chk($sformatf("v%0d_stall", i),
          {31'h0, bus.Icache_stall_flag_o}, {31'h0, q[i].stall});
      chk($sformatf("v%0d_mreq", i),
          {31'h0, bus.mem_req_o}, {31'h0, q[i].mreq});
      chk($sformatf("v%0d_addr", i), bus.mem_addr_o, q[i].addr);
      chk($sformatf("v%0d_ival", i),
          {31'h0, bus.Icache_inst_valid_o}, {31'h0, q[i].ival});
      chk($sformatf("v%0d_inst", i), bus.Icache_inst_o, q[i].inst);
      tick();
    end

    // reset in the middle of a refill of line 0x10
    drive(32'h10, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("mr_mreq", {31'h0, bus.mem_req_o}, 32'h1);
    chk("mr_addr", bus.mem_addr_o, 32'h10);
    drive(32'h10, 1'b1, 1'b0, 1'b1, 32'hE0);
    tick();
    drive(32'h10, 1'b1, 1'b0, 1'b1, 32'hE1);
    tick();
    rst = 1'b1;
    drive(32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    chk("mr_rst_mreq", {31'h0, bus.mem_req_o}, 32'h0);
    chk("mr_rst_addr", bus.mem_addr_o, 32'h0);
`ifdef ICACHE_PERF_CNT_EN
    chk("mr_hit_cnt", hit_cnt, 32'h0);
    chk("mr_miss_cnt", miss_cnt, 32'h0);
`endif
    drive(32'h10, 1'b0, 1'b0, 1'b1, 32'hE2);
    tick();
    drive(32'h10, 1'b0, 1'b0, 1'b1, 32'hE3);
    tick();
    chk("mr_late_mreq", {31'h0, bus.mem_req_o}, 32'h0);
    drive(32'h10, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("mr_refetch_stall", {31'h0, bus.Icache_stall_flag_o}, 32'h1);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = bus.mem_req_o;
    end
    chk("mr_req_seen", {31'h0, seen}, 32'h1);
    chk("mr_re_addr", bus.mem_addr_o, 32'h10);
    for (int b = 0; b < 4; b++) begin
      drive(32'h10, 1'b1, 1'b0, 1'b1, 32'hC0 + b);
      tick();
    end
    drive(32'h10, 1'b1, 1'b0, 1'b0, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = bus.Icache_inst_valid_o;
    end
    chk("mr_ival_seen", {31'h0, seen}, 32'h1);
    chk("mr_inst", bus.Icache_inst_o, 32'hC0);
`ifdef ICACHE_PERF_CNT_EN
    chk("mr_miss_cnt_after", miss_cnt, 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
